fib_req_arbiter: RTL and testbench
==================================

Name: fib_req_arbiter

Overview:
Round-robin scheduler that shares one fibonacci_calculator instance between NUM_REQ independent requesters. It accepts one request at a time and drives the calculator's reset, begin_fibo and input_s. It waits for done, or gives up after a timeout, and returns fibo_out and the cycle count to the granted requester. It sits between the client logic and the calculator; the calculator's ports connect directly to the calc_* ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 5, width of the Fibonacci index (calculator input_s)
DATA_W, 16, width of the result (calculator fibo_out)
TIMEOUT_CYCLES, 1024, maximum number of WAIT cycles before an error response
CNT_W, 11, width of resp_cycles; must hold TIMEOUT_CYCLES+1

Ports:
clk  in  1  system clock; all logic is rising-edge
reset  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request; held until the matching req_ready
req_index  in  NUM_REQ*IDX_W  per-requester index; slice i is bits [i*IDX_W +: IDX_W]
req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
resp_valid  out  NUM_REQ  one-hot, one-cycle response pulse to the granted requester
resp_data  out  DATA_W  result; valid while any resp_valid is high
resp_error  out  1  timeout flag; valid while any resp_valid is high
resp_cycles  out  CNT_W  calculator cycles, START cycle counted as 1
calc_reset  out  1  calculator reset, active-high
calc_begin  out  1  calculator begin_fibo
calc_input  out  IDX_W  calculator input_s
calc_done  in  1  calculator done
calc_fibo  in  DATA_W  calculator fibo_out

Behaviour:
- State machine: IDLE, CLR, START, WAIT, RESP.
- Reset (reset=0 at a clk edge):
  - state goes to IDLE and the rr pointer to 0;
  - req_ready, resp_valid, resp_data, resp_error, resp_cycles, calc_begin and calc_input all go to 0;
  - calc_reset=1 while reset is low, so the calculator is held in reset;
  - reset low in any state, including mid-WAIT, aborts the job and issues no response.
- IDLE:
  - Arbitration: the first i with req_valid[i]=1, searched from the rr pointer upward with wrap-around.
  - On a grant, req_ready[i]=1 for that cycle; req_index slice i is latched into calc_input; the grant id is latched; rr becomes (i+1) mod NUM_REQ; next state is CLR.
  - With no valid request: stay in IDLE and rr is unchanged.
- CLR: calc_reset=1 for exactly one cycle, then go to START.
- START:
  - calc_begin=1 for exactly one cycle with calc_input stable;
  - the cycle counter is loaded with 1; go to WAIT.
- calc_input holds the latched index from CLR through RESP.
- WAIT:
  - Each cycle, calc_done is sampled and the counter increments when done is 0.
  - When calc_done=1: latch calc_fibo into resp_data, set resp_error=0, load resp_cycles from the counter, go to RESP.
  - When the counter reaches TIMEOUT_CYCLES with done still 0: set resp_data=0, resp_error=1, resp_cycles=TIMEOUT_CYCLES, go to RESP.
  - If done and the timeout limit occur in the same cycle, done wins.
- calc_done is ignored in IDLE, CLR and START, so a stale done from a previous job is never used.
- RESP:
  - resp_valid[grant]=1 for one cycle; resp_data, resp_error and resp_cycles stay stable until the next RESP.
  - Go to IDLE. A new grant is possible in the cycle after RESP, so at most one job is in flight.
- Minimum latency: accept at cycle t, CLR t+1, START t+2, done at t+3 earliest, resp_valid at t+4.
- Requesters:
  - A requester may deassert req_valid after its req_ready.
  - A requester that deasserts req_valid before its grant is simply skipped.
  - Re-asserting req_valid during its own job is allowed; it is queued by arbitration after RESP.
- calc_reset=0 and calc_begin=0 in all states other than those above.

Test Plan:
- Single request: req_valid[0]=1, index=10 -> req_ready[0] pulse, then calc_reset 1 cycle, then calc_begin 1 cycle. resp_valid[0] pulses with resp_data=55 and resp_error=0; nothing is asserted on other ports.
- Simultaneous requests: all four requesters raise req_valid at once with indices 1,2,3,4, starting from reset -> responses arrive in order 0,1,2,3 with data 1,1,2,3, and exactly one req_ready per requester.
- Fairness: req0 (index 5) and req2 (index 6) held valid continuously for 6 jobs -> grants alternate 0,2,0,2,0,2 with data 5,8 alternating. Requesters 1 and 3 are never granted.
- Max index: index 23 -> resp_data=28657. resp_cycles equals the calculator's done cycle count with START counted as 1, so a 3-cycle stub calculator gives 3.
- Timeout: calculator stub with done tied to 0 -> resp_valid exactly TIMEOUT_CYCLES cycles after START, with resp_error=1, resp_data=0, resp_cycles=1024. The next request then completes normally.
- Reset mid-job: reset=0 for 1 cycle during WAIT -> no resp_valid, all outputs 0, calc_reset=1 during reset. After reset, a pending req1 is granted first (rr=0 scan, req0 idle) and returns the correct value.

Source files
------------

// File: rtl/fib_req_arbiter.sv
// Round-robin front end that shares one fibonacci_calculator between NUM_REQ
// requesters, one job at a time, with a WAIT-state timeout and per-job cycle count.
module fib_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 5,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] req_index,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     resp_error,
  output logic [CNT_W-1:0]         resp_cycles,
  output logic                     calc_reset,
  output logic                     calc_begin,
  output logic [IDX_W-1:0]         calc_input,
  input  logic                     calc_done,
  input  logic [DATA_W-1:0]        calc_fibo
);

  localparam int          PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR = NUM_REQ;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLR   = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  // The START cycle already counts as 1, so the limit is hit one WAIT cycle
  // before the counter itself would read TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [NUM_REQ-1:0] ONE_REQ   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [PW-1:0]    rr;
  logic [PW-1:0]    grant;
  logic [PW-1:0]    pick;
  logic [PW-1:0]    cand;
  logic [PW-1:0]    rr_next;
  logic             found;
  logic [CNT_W-1:0] cnt;
  int unsigned      j;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    j     = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      j = rr + k;
      if (j >= NR) j = j - NR;
      cand = PW'(j);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign rr_next = (pick == PW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;

  assign req_ready  = (reset && state == IDLE && found) ? (ONE_REQ << pick) : '0;
  assign resp_valid = (reset && state == RESP) ? (ONE_REQ << grant) : '0;
  assign calc_reset = !reset || (state == CLR);
  assign calc_begin = reset && (state == START);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rr          <= '0;
      grant       <= '0;
      cnt         <= '0;
      calc_input  <= '0;
      resp_data   <= '0;
      resp_error  <= 1'b0;
      resp_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant      <= pick;
            calc_input <= req_index[pick*IDX_W +: IDX_W];
            rr         <= rr_next;
            state      <= CLR;
          end
        end
        CLR: state <= START;
        START: begin
          cnt   <= CNT_W'(1);
          state <= WAIT;
        end
        WAIT: begin
          if (calc_done) begin
            resp_data   <= calc_fibo;
            resp_error  <= 1'b0;
            resp_cycles <= cnt;
            state       <= RESP;
          end else if (cnt == CNT_LAST) begin
            resp_data   <= '0;
            resp_error  <= 1'b1;
            resp_cycles <= CNT_TIMEOUT;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_req_arbiter.sv
// Directed bench for fib_req_arbiter with a behavioural calculator stub whose
// done latency (counted from the START cycle as 1) and hang mode are programmable.
module tb_fib_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [19:0] req_index;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [15:0] resp_data;
  logic        resp_error;
  logic [10:0] resp_cycles;
  logic        calc_reset;
  logic        calc_begin;
  logic [4:0]  calc_input;
  logic        calc_done;
  logic [15:0] calc_fibo;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fib_req_arbiter #(
    .NUM_REQ(4), .IDX_W(5), .DATA_W(16), .TIMEOUT_CYCLES(1024), .CNT_W(11)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .resp_cycles(resp_cycles),
    .calc_reset(calc_reset), .calc_begin(calc_begin), .calc_input(calc_input),
    .calc_done(calc_done), .calc_fibo(calc_fibo)
  );

  // calculator stub: done stays high until the next calc_reset
  int unsigned stub_lat  = 3;
  bit          stub_hang = 1'b0;
  logic        stub_busy;
  int unsigned stub_cnt;
  logic [4:0]  stub_idx;

  function automatic logic [15:0] fib(input logic [4:0] n);
    logic [15:0] a, b, t;
    a = 16'd0;
    b = 16'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  always @(posedge clk) begin
    if (calc_reset) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else if (calc_begin) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 1;
      stub_idx  <= calc_input;
    end else if (stub_busy && stub_cnt < 4000) begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  assign calc_done = stub_busy && !stub_hang && (stub_cnt >= stub_lat);
  assign calc_fibo = calc_done ? fib(stub_idx) : 16'h0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int unsigned id;
    int unsigned idx;
    int unsigned lat;
    bit          hang;
    int unsigned data;
    bit          err;
    int unsigned cycles;
    int unsigned wait_n;
  } vec_t;

  vec_t vecs [9];

  task automatic do_reset();
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Single job from an idle arbiter; returns at the negedge of the RESP cycle.
  task automatic run_job(input vec_t v);
    logic [3:0]  oh;
    bit          got;
    int unsigned n;
    oh = 4'b0001 << v.id;
    @(posedge clk); #1;
    stub_lat  = v.lat;
    stub_hang = v.hang;
    req_index[v.id*5 +: 5] = 5'(v.idx);
    req_valid[v.id] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("accept", {28'd0, req_ready}, {28'd0, oh});
    @(posedge clk); #1;
    req_valid[v.id] = 1'b0;
    @(negedge clk);
    chk("clr_reset", {31'd0, calc_reset}, 1);
    chk("clr_begin", {31'd0, calc_begin}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("start_begin", {30'd0, calc_reset, calc_begin}, 1);
    chk("start_input", {27'd0, calc_input}, v.idx);
    n = 0;
    got = 1'b0;
    while (!got && n < 1100) begin
      @(posedge clk); #1;
      n++;
      @(negedge clk);
      if (resp_valid != '0) got = 1'b1;
    end
    chk("resp_wait", n, v.wait_n);
    chk("resp_valid", {28'd0, resp_valid}, {28'd0, oh});
    chk("resp_data", {16'd0, resp_data}, v.data);
    chk("resp_error", {31'd0, resp_error}, {31'd0, v.err});
    chk("resp_cycles", {21'd0, resp_cycles}, v.cycles);
  endtask

  logic [3:0]  drop;
  logic [3:0]  exp_oh [6];
  int unsigned exp_dat [6];
  logic [3:0]  got_oh [6];
  int unsigned got_dat [6];
  int unsigned acc [4];
  int unsigned nresp;
  int unsigned nacc;
  bit          done_flag;

  initial begin
    vecs[0] = '{0, 10,    3, 1'b0,    55, 1'b0,    3,    4};
    vecs[1] = '{3, 23,    3, 1'b0, 28657, 1'b0,    3,    4};
    vecs[2] = '{2,  5,    1, 1'b0,     5, 1'b0,    1,    2};
    vecs[3] = '{1,  0,    2, 1'b0,     0, 1'b0,    2,    3};
    vecs[4] = '{0, 12,    5, 1'b0,   144, 1'b0,    5,    6};
    vecs[5] = '{2,  7,    0, 1'b1,     0, 1'b1, 1024, 1024};
    vecs[6] = '{3,  4,    2, 1'b0,     3, 1'b0,    2,    3};
    vecs[7] = '{0,  9, 1023, 1'b0,    34, 1'b0, 1023, 1024};
    vecs[8] = '{1, 31,    4, 1'b0, 35549, 1'b0,    4,    5};

    reset     = 1'b0;
    req_valid = '1;
    req_index = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_ready", {28'd0, req_ready}, 0);
    chk("rst_resp_valid", {28'd0, resp_valid}, 0);
    chk("rst_resp_bus", {4'd0, resp_data, resp_error, resp_cycles}, 0);
    chk("rst_calc", {25'd0, calc_reset, calc_begin, calc_input}, 32'h40);
    @(posedge clk); #1;
    req_valid = '0;
    reset     = 1'b1;
    @(negedge clk);
    chk("rst_release_calc_reset", {31'd0, calc_reset}, 0);

    for (int i = 0; i < 9; i++) run_job(vecs[i]);

    // all four at once from reset: served 0,1,2,3
    do_reset();
    stub_lat  = 2;
    stub_hang = 1'b0;
    req_index = {5'd4, 5'd3, 5'd2, 5'd1};
    req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      exp_oh[k] = 4'b0001 << k;
      acc[k]    = 0;
    end
    exp_dat[0] = 1; exp_dat[1] = 1; exp_dat[2] = 2; exp_dat[3] = 3;
    nresp = 0;
    for (int c = 0; c < 200 && nresp < 4; c++) begin
      @(negedge clk);
      drop = req_ready;
      for (int k = 0; k < 4; k++) if (req_ready[k]) acc[k]++;
      if (resp_valid != '0) begin
        got_oh[nresp]  = resp_valid;
        got_dat[nresp] = resp_data;
        nresp++;
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~drop;
    end
    chk("sim_nresp", nresp, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < int'(nresp)) begin
        chk("sim_order", {28'd0, got_oh[k]}, {28'd0, exp_oh[k]});
        chk("sim_data", got_dat[k], exp_dat[k]);
      end
      chk("sim_accepts", acc[k], 1);
    end

    // req0 and req2 held continuously: grants alternate
    req_index = {5'd0, 5'd6, 5'd0, 5'd5};
    req_valid = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      exp_oh[k]  = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      exp_dat[k] = (k % 2 == 0) ? 5 : 8;
    end
    for (int k = 0; k < 4; k++) acc[k] = 0;
    nresp = 0;
    for (int c = 0; c < 300 && nresp < 6; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (req_ready[k]) acc[k]++;
      if (resp_valid != '0) begin
        got_oh[nresp]  = resp_valid;
        got_dat[nresp] = resp_data;
        nresp++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("fair_nresp", nresp, 6);
    for (int k = 0; k < 6; k++) begin
      if (k < int'(nresp)) begin
        chk("fair_order", {28'd0, got_oh[k]}, {28'd0, exp_oh[k]});
        chk("fair_data", got_dat[k], exp_dat[k]);
      end
    end
    chk("fair_acc0", acc[0], 3);
    chk("fair_acc2", acc[2], 3);
    chk("fair_acc13", acc[1] + acc[3], 0);

    // reset during WAIT of a req2 job, with req1 and req3 pending
    stub_hang = 1'b1;
    req_index = {5'd13, 5'd8, 5'd11, 5'd0};
    req_valid = 4'b0100;
    nacc = 0;
    for (int c = 0; c < 20 && nacc == 0; c++) begin
      @(negedge clk);
      if (req_ready != '0) nacc++;
      @(posedge clk); #1;
    end
    chk("mid_accept", nacc, 1);
    req_valid = '0;
    repeat (5) begin @(posedge clk); #1; end
    req_valid = 4'b1010;
    reset     = 1'b0;
    @(negedge clk);
    chk("mid_rst_calc_reset", {31'd0, calc_reset}, 1);
    chk("mid_rst_pulses", {24'd0, req_ready, resp_valid}, 0);
    chk("mid_rst_begin", {31'd0, calc_begin}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_after_bus", {4'd0, resp_data, resp_error, resp_cycles}, 0);
    chk("mid_after_calc", {26'd0, calc_begin, calc_input}, 0);
    chk("mid_after_grant", {28'd0, req_ready}, 32'h2);
    chk("mid_after_resp", {28'd0, resp_valid}, 0);
    @(posedge clk); #1;
    req_valid = '0;
    stub_hang = 1'b0;
    stub_lat  = 3;
    done_flag = 1'b0;
    for (int c = 0; c < 50 && !done_flag; c++) begin
      @(negedge clk);
      if (resp_valid != '0) done_flag = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("mid_resp_valid", {28'd0, resp_valid}, 32'h2);
    chk("mid_resp_data", {16'd0, resp_data}, 89);
    chk("mid_resp_error", {31'd0, resp_error}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
